// File: rtl/conv_kxk_pkg.sv
// Shared types and width helpers for the KxK streaming stencil.
//   state_t     : frame sequencing states
//   acc_width   : adder-tree width, wide enough for K*K full-width products
//   win_outputs : number of fully-valid windows (results) in one frame
package conv_kxk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  function automatic int win_outputs(input int img_w, input int img_h, input int k);
    return (img_w - k + 1) * (img_h - k + 1);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO holding finished results until the sink accepts them.
//   clk, rst_n      : clock, synchronous active-low reset
//   clear           : drops all contents (frame abort)
//   push, push_data : write side; a push into a full FIFO is ignored
//   pop, pop_data   : read side; pop_data is the head entry, 0 when empty
//   count           : number of stored entries
module stream_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));

  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

  // Explicit wrap so non power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv_kxk_stream.sv
// KxK weighted-sum stencil over a raster-order pixel stream.
//   clk, rst_n                     : clock, synchronous active-low reset
//   flush                          : start of frame; aborts a frame in progress
//   coeff                          : K*K weights, row-major, entry 0 at LSBs
//   hw_input_stencil_read_en/_valid/read    : pixel input stream
//   hw_output_stencil_write_valid/_ready/write : result output stream
//   done                           : pulse after the last result of a frame leaves
//
// state    | meaning
// ST_IDLE  | waiting for flush
// ST_RUN   | accepting pixels of the current frame
// ST_DRAIN | all pixels taken, emptying pipeline and FIFO
module conv_kxk_stream
  import conv_kxk_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int K         = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [K*K*DATA_W-1:0]   coeff,
  output logic                    hw_input_stencil_read_en,
  input  logic                    hw_input_stencil_read_valid,
  input  logic [DATA_W-1:0]       hw_input_stencil_read,
  output logic                    hw_output_stencil_write_valid,
  input  logic                    hw_output_stencil_write_ready,
  output logic [DATA_W-1:0]       hw_output_stencil_write,
  output logic                    done
);

  localparam int ACC_W       = acc_width(DATA_W, K);
  localparam int WIN_OUTPUTS = win_outputs(IMG_W, IMG_H, K);
  localparam int COL_W       = $clog2(IMG_W);
  localparam int ROW_W       = $clog2(IMG_H);
  localparam int CNT_W       = $clog2(OUT_DEPTH + 1);
  localparam int RES_W       = $clog2(WIN_OUTPUTS + 1);
  localparam int LB_ROWS     = (K > 1) ? K - 1 : 1;

  state_t                  state;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic [RES_W-1:0]        res_left;
  logic [K*K*DATA_W-1:0]   coeff_q;
  logic                    win_v;    // window register holds a valid window
  logic                    prod_v;   // product registers hold a valid window

  logic [DATA_W-1:0]       lb      [LB_ROWS][IMG_W];
  logic [DATA_W-1:0]       win     [K][K];
  logic [DATA_W-1:0]       col_new [K];
  logic [2*DATA_W-1:0]     prod    [K*K];
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-DATA_W-1:0] acc_hi_unused;

  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          credit_used;
  logic                    accept;
  logic                    pop;
  logic                    last_pix;
  logic                    win_ok;

  // Credit counts results already in flight so the FIFO can never overflow.
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(win_v) + (CNT_W+1)'(prod_v);
  assign hw_input_stencil_read_en = (state == ST_RUN) &&
                                    (credit_used < (CNT_W+1)'(OUT_DEPTH));

  assign accept   = hw_input_stencil_read_en && hw_input_stencil_read_valid;
  assign pop      = hw_output_stencil_write_valid && hw_output_stencil_write_ready;
  assign last_pix = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign win_ok   = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

  assign hw_output_stencil_write_valid = (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      res_left <= '0;
      coeff_q  <= '0;
      win_v    <= 1'b0;
      prod_v   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done   <= 1'b0;
      prod_v <= win_v;
      win_v  <= 1'b0;
      if (flush) begin
        // Flush beats a same-cycle pixel accept; that pixel is dropped.
        state    <= ST_RUN;
        col      <= '0;
        row      <= '0;
        res_left <= RES_W'(WIN_OUTPUTS);
        coeff_q  <= coeff;
        prod_v   <= 1'b0;
      end else begin
        if (pop) res_left <= res_left - 1'b1;
        case (state)
          ST_RUN: begin
            if (accept) begin
              win_v <= win_ok;
              if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if (last_pix) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            // Final transfer implies pipeline and FIFO are now empty.
            if (pop && res_left == RES_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  // Newest window column: K-1 previous rows from the line buffers, then the pixel.
  always_comb begin
    for (int r = 0; r < K; r++) col_new[r] = '0;
    for (int r = 0; r < K - 1; r++) col_new[r] = lb[r][col];
    col_new[K-1] = hw_input_stencil_read;
  end

  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      for (int r = 0; r < K - 1; r++) lb[r][col] <= col_new[r+1];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        prod[r*K+c] <= (2*DATA_W)'(win[r][c]) *
                       (2*DATA_W)'(coeff_q[(r*K+c)*DATA_W +: DATA_W]);
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < K * K; i++) acc = acc + ACC_W'(prod[i]);
  end

  // Output wraps to DATA_W; the high sum bits are intentionally dropped.
  assign acc_hi_unused = acc[ACC_W-1:DATA_W];

  stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (prod_v),
    .push_data (acc[DATA_W-1:0]),
    .pop       (pop),
    .pop_data  (hw_output_stencil_write),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int K  = 3;
  localparam int OD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [K*K*DW-1:0] coeff = '0;
  logic              read_en;
  logic              read_valid = 1'b0;
  logic [DW-1:0]     read_data = '0;
  logic              write_valid;
  logic              write_ready = 1'b1;
  logic [DW-1:0]     write_data;
  logic              done;

  always #5 clk = ~clk;

  conv_kxk_stream #(
    .DATA_W (DW), .IMG_W (IW), .IMG_H (IH), .K (K), .OUT_DEPTH (OD)
  ) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .flush                         (flush),
    .coeff                         (coeff),
    .hw_input_stencil_read_en      (read_en),
    .hw_input_stencil_read_valid   (read_valid),
    .hw_input_stencil_read         (read_data),
    .hw_output_stencil_write_valid (write_valid),
    .hw_output_stencil_write_ready (write_ready),
    .hw_output_stencil_write       (write_data),
    .done                          (done)
  );

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] exp_q[$];
  int            produced = 0;
  int            popped = 0;
  int            n_acc = 0;
  int            done_cnt = 0;
  int            credit_viol = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [DW-1:0] exp_val(input int kind, input int y, input int x);
    case (kind)
      0:       return DW'(9 * (8 * y + x) + 81);
      1:       return DW'(8 * y + x + 9);
      default: return 16'h2000;
    endcase
  endfunction

  function automatic logic [K*K*DW-1:0] coeff_all_ones();
    logic [K*K*DW-1:0] c;
    c = '0;
    for (int i = 0; i < K * K; i++) c[i*DW +: DW] = 16'd1;
    return c;
  endfunction

  function automatic logic [K*K*DW-1:0] coeff_centre();
    logic [K*K*DW-1:0] c;
    c = '0;
    c[4*DW +: DW] = 16'd1;
    return c;
  endfunction

  // Monitor: pops the scoreboard whenever a transfer is about to occur.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if ((produced - popped) >= OD && read_en) credit_viol++;
      if (write_valid && write_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %0d with none outstanding", write_data);
        end else begin
          check("result", write_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_pixel(input logic [DW-1:0] d, output bit ok);
    read_valid = 1'b1;
    read_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (read_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    else begin
      n_checks++;
      $display("FAIL accept_timeout: got no read_en expected read_en within 200 cycles");
    end
    #1 read_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int npix, input bit push);
    bit ok;
    for (int i = 0; i < npix; i++) begin
      int y, x;
      y = i / IW;
      x = i % IW;
      send_pixel((kind == 2) ? 16'h2000 : DW'(i), ok);
      if (ok) begin
        n_acc++;
        if (y >= K - 1 && x >= K - 1) begin
          produced++;
          if (push) exp_q.push_back(exp_val(kind, y - K + 1, x - K + 1));
        end
      end
    end
  endtask

  task automatic do_flush(input logic [K*K*DW-1:0] c);
    coeff = c;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    produced = popped;
    n_acc = 0;
  endtask

  task automatic wait_frame(input int d0);
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0 && done_cnt > d0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("results_left", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_read_en", read_en, 0);
    check("reset_write_valid", write_valid, 0);
    check("reset_write", write_data, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp, all-ones weights
    d0 = done_cnt;
    do_flush(coeff_all_ones());
    send_frame(0, IW * IH, 1'b1);
    wait_frame(d0);

    // Ramp, centre tap only
    d0 = done_cnt;
    do_flush(coeff_centre());
    send_frame(1, IW * IH, 1'b1);
    wait_frame(d0);

    // Constant 0x2000, sum wraps
    d0 = done_cnt;
    do_flush(coeff_all_ones());
    send_frame(2, IW * IH, 1'b1);
    wait_frame(d0);

    // Sink stalls 20 cycles mid-frame
    d0 = done_cnt;
    do_flush(coeff_all_ones());
    fork
      send_frame(0, IW * IH, 1'b1);
      begin
        for (int t = 0; t < 600 && n_acc < 20; t++) @(posedge clk);
        #1 write_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("stall_read_en", read_en, 0);
        write_ready = 1'b1;
      end
    join
    wait_frame(d0);
    check("credit_violations", credit_viol, 0);

    // Abort after 20 pixels, then a full frame
    write_ready = 1'b0;
    do_flush(coeff_all_ones());
    send_frame(0, 20, 1'b0);
    do_flush(coeff_all_ones());
    check("abort_write_valid", write_valid, 0);
    write_ready = 1'b1;
    d0 = done_cnt;
    send_frame(0, IW * IH, 1'b1);
    wait_frame(d0);

    // Reset in DRAIN
    d0 = done_cnt;
    do_flush(coeff_all_ones());
    send_frame(0, IW * IH, 1'b1);
    write_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("drain_rst_read_en", read_en, 0);
    check("drain_rst_write_valid", write_valid, 0);
    check("drain_rst_write", write_data, 0);
    check("drain_rst_done", done, 0);
    exp_q.delete();
    produced = popped;
    write_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_read_en", read_en, 0);
    check("idle_write_valid", write_valid, 0);
    check("no_done_after_reset", done_cnt - d0, 0);

    // Recovery frame
    d0 = done_cnt;
    do_flush(coeff_all_ones());
    send_frame(0, IW * IH, 1'b1);
    wait_frame(d0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_kxk_stream.md
Name: conv_kxk_stream

Overview:
- Parametrised successor to the fixed 3x3 stencil accelerator: streams a raster-order image in, computes a KxK weighted-sum stencil over every fully-valid window, and streams results out.
- Adds runtime coefficients, ready/valid back-pressure on both streams, and frame-level control (start, abort, done) to the existing read_en/write_valid stream style.
- Sits between the global input wrapper and the output stencil sink in generated accelerator tops.

Parameters:
- DATA_W, 16, pixel, coefficient and output width.
- IMG_W, 64, image width in pixels (>= K).
- IMG_H, 64, image height in rows (>= K).
- K, 3, stencil size (odd, 1..7).
- OUT_DEPTH, 4, output FIFO depth (>= 4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  start-of-frame pulse; aborts any frame in progress.
- coeff  in  K*K*DATA_W  weights, row-major, entry 0 at LSBs; latched on flush.
- hw_input_stencil_read_en  out  1  block requests a pixel.
- hw_input_stencil_read_valid  in  1  source has a pixel.
- hw_input_stencil_read  in  DATA_W  pixel data.
- hw_output_stencil_write_valid  out  1  result available.
- hw_output_stencil_write_ready  in  1  sink accepts.
- hw_output_stencil_write  out  DATA_W  result.
- done  out  1  one-cycle pulse when the last result of a frame is accepted.

Behaviour:
- Reset (rst_n low at posedge) takes priority over everything else.
  - Resets: state IDLE; read_en, write_valid, done = 0; write = 0.
  - Also clears counters, the line buffers' valid tracking, the pipeline and the FIFO.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on flush.
  - RUN -> DRAIN after pixel IMG_W*IMG_H-1 is accepted.
  - DRAIN -> IDLE when the FIFO is empty, the pipeline is empty and the final result has been accepted; done pulses in that cycle.
- flush in RUN or DRAIN:
  - Discards the pipeline and FIFO contents and resets counters.
  - Re-latches coeff and re-enters RUN the next cycle.
  - No result from the aborted frame appears after flush.
- Input handshake:
  - A pixel is accepted at a posedge when read_en and read_valid are both high.
  - read_en = (state==RUN) && (fifo_count + pipe_count) < OUT_DEPTH.
  - read_en is driven from registers only; there is no combinational path from read_valid.
- Pixel counters:
  - col wraps at IMG_W-1 and increments row; row ends at IMG_H-1.
  - Counters advance only on accept.
- Line buffers:
  - K-1 rows of IMG_W entries, plus a KxK window register shifted on accept.
- Window-valid rule:
  - A result is emitted for an accepted pixel at (row, col) iff row >= K-1 and col >= K-1.
  - The result is for the window whose top-left corner is (row-K+1, col-K+1).
  - Results per frame: (IMG_W-K+1)*(IMG_H-K+1), in raster order.
- Arithmetic:
  - Unsigned products DATA_W x DATA_W.
  - Sum in ACC_W = 2*DATA_W + clog2(K*K).
  - Output is the low DATA_W bits (wrap, no saturation).
- Latency: 2-stage pipeline (multiply, adder tree). A result enters the FIFO 2 cycles after accept of the window's last pixel.
- Output handshake:
  - A transfer occurs when write_valid && write_ready.
  - write and write_valid are held stable while ready is low.
  - The FIFO never overflows, because the credit rule in read_en counts in-flight results.
- Simultaneous accept of the last pixel and flush: flush wins and the pixel is discarded.

Decomposition:
- Package conv_kxk_pkg:
  - state enum.
  - clog2-based ACC_W function.
  - WIN_OUTPUTS localparam function of IMG_W, IMG_H, K.
- Sub-module stream_fifo:
  - Synchronous FIFO, DATA_W x OUT_DEPTH.
  - Ports: count output, push/pop, clear.
  - Reused by the output stage.
- Line buffers, window and adder tree stay in the top.

Test Plan:
- IMG_W=8, IMG_H=6, K=3, all coeff=1, ramp input 0..47, ready always 1 -> 24 results = 9*(8y+x)+81 for y 0..3, x 0..5. First result 81, last 342. done pulses once.
- Same frame, only centre coeff=1, others 0 -> results 8y+x+9, i.e. 9..38 over the valid windows.
- All coeff=1, constant input 0x2000 -> every result 0x2000 (0x12000 wrapped to 16 bits).
- Ramp frame with ready low for 20 cycles mid-frame -> read_en drops within one cycle once the FIFO credit is exhausted. Output sequence is identical to the first scenario; no loss or duplication.
- flush after 20 accepted pixels, then a full ramp frame -> only the 24 results of the new frame appear, starting at 81.
- rst_n low for 1 cycle mid-DRAIN -> next cycle IDLE with all outputs 0. No done pulse. Block idles until the next flush.
